fsmd_divchain: RTL and testbench

//  Parametrised multi-cycle FSMD: result = ((xin<<SH)/K) - ((yin/K)/(xin*xin)).

---
 rtl/fsmd_pkg.sv | 19 +
 rtl/fsmd_divchain_seq_divider.sv | 85 ++++++++
 rtl/fsmd_divchain.sv | 174 +++++++++++++++++
 tb/tb_fsmd_divchain.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fsmd_pkg.sv
// Shared types and helpers for the fsmd_divchain FSMD.
// Holds the controller state enum and the divider iteration-count helper.
package fsmd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DIV_Y = 3'd2,
    DIV_Z = 3'd3,
    DIV_X = 3'd4,
    OUT   = 3'd5
  } fsmd_state_t;

  // Quotient bits produced after the load cycle (one per clock).
  function automatic int unsigned div_iters(input int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/fsmd_divchain_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   go          load operands and start (DW+1 cycles to q_valid)
//   dividend    DW-bit dividend, sampled with go
//   divisor     DW-bit divisor, sampled with go (0 -> all-ones quotient)
//   quotient    DW-bit quotient, held until the next go
//   q_valid     one-cycle pulse when quotient is final
module seq_divider
  import fsmd_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          q_valid
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic          q_valid_q, q_valid_d;
  logic [DW:0]   rem_shift_c;

  // Shift in the next dividend bit; subtract when the partial remainder fits.
  always_comb begin
    active_d    = active_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_valid_d   = 1'b0;
    rem_shift_c = {rem_q, quo_q[DW-1]};
    if (go) begin
      active_d = 1'b1;
      cnt_d    = CW'(div_iters(DW));
      rem_d    = '0;
      quo_d    = dividend;
      dvs_d    = divisor;
    end else if (active_q) begin
      if (rem_shift_c >= {1'b0, dvs_q}) begin
        rem_d = DW'(rem_shift_c - {1'b0, dvs_q});
        quo_d = {quo_q[DW-2:0], 1'b1};
      end else begin
        rem_d = rem_shift_c[DW-1:0];
        quo_d = {quo_q[DW-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        active_d  = 1'b0;
        q_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      q_valid_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign quotient = quo_q;
  assign q_valid  = q_valid_q;

endmodule

// File: rtl/fsmd_divchain.sv
// fsmd_divchain: result = ((x<<SH)/K) - ((y/K)/(x*x)), mod 2**DW, DW = 2*W.
// All three divisions share one seq_divider, sequenced by a small FSM.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start        request, accepted only while ready
//   xin, yin     W-bit operands captured on accept
//   ready        high in IDLE only
//   busy         high in every non-IDLE state
//   done         one-cycle pulse when result updates
//   result       DW-bit result, held until next done
//   err          divide-by-zero flag (only with FSMD_DIVZERO_ERR_EN defined)
// Optional feature macro: FSMD_DIVZERO_ERR_EN.
module fsmd_divchain
  import fsmd_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned K  = 3,
  parameter int unsigned SH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     xin,
  input  logic [W-1:0]     yin,
  output logic             ready,
  output logic             busy,
  output logic             done,
`ifdef FSMD_DIVZERO_ERR_EN
  output logic             err,
`endif
  output logic [2*W-1:0]   result
);

  localparam int unsigned DW = 2 * W;

  fsmd_state_t   state_q, state_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] y_q, y_d;
  logic [DW-1:0] z_q, z_d;
  logic [DW-1:0] y2_q, y2_d;
  logic [DW-1:0] x1_q, x1_d;
  logic [DW-1:0] result_q, result_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          div_go_c;
  logic [DW-1:0] div_dividend_c;
  logic [DW-1:0] div_divisor_c;
  logic [DW-1:0] div_quotient;
  logic          div_q_valid;

  seq_divider #(.DW(DW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (div_go_c),
    .dividend (div_dividend_c),
    .divisor  (div_divisor_c),
    .quotient (div_quotient),
    .q_valid  (div_q_valid)
  );

  // Next-state, datapath captures and divider launches.
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    z_d            = z_q;
    y2_d           = y2_q;
    x1_d           = x1_q;
    result_d       = result_q;
    err_d          = err_q;
    done_d         = 1'b0;
    div_go_c       = 1'b0;
    div_dividend_c = '0;
    div_divisor_c  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = DW'(xin);
          y_d     = DW'(yin);
          z_d     = DW'(xin) * DW'(xin);
          state_d = LOAD;
        end
      end
      LOAD: begin
        div_go_c       = 1'b1;
        div_dividend_c = y_q;
        div_divisor_c  = DW'(K);
        state_d        = DIV_Y;
      end
      DIV_Y: begin
        // Chain y1 straight from the divider's held quotient into the next launch.
        if (div_q_valid) begin
          div_go_c       = 1'b1;
          div_dividend_c = div_quotient;
          div_divisor_c  = z_q;
          state_d        = DIV_Z;
        end
      end
      DIV_Z: begin
        if (div_q_valid) begin
          y2_d           = div_quotient;
          div_go_c       = 1'b1;
          div_dividend_c = x_q << SH;
          div_divisor_c  = DW'(K);
          state_d        = DIV_X;
        end
      end
      DIV_X: begin
        if (div_q_valid) begin
          x1_d    = div_quotient;
          state_d = OUT;
        end
      end
      OUT: begin
        result_d = x1_q - y2_q;
        err_d    = 1'b0;
`ifdef FSMD_DIVZERO_ERR_EN
        if (x_q == '0) begin
          result_d = '0;
          err_d    = 1'b1;
        end
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      y2_q     <= '0;
      x1_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      y2_q     <= y2_d;
      x1_q     <= x1_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef FSMD_DIVZERO_ERR_EN
  assign err    = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_fsmd_divchain.sv
// Self-checking bench for fsmd_divchain (W=4, K=3, SH=1) against an
// arithmetic reference model; honours FSMD_DIVZERO_ERR_EN if defined.
module tb_fsmd_divchain;

  localparam int unsigned W  = 4;
  localparam int unsigned DW = 2 * W;
  localparam int unsigned LAT = 3 * (DW + 1) + 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  xin;
  logic [W-1:0]  yin;
  logic          ready;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
`ifdef FSMD_DIVZERO_ERR_EN
  logic          err;
`endif

  int total = 0;
  int bad   = 0;

  fsmd_divchain #(.W(W), .K(3), .SH(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .xin    (xin),
    .yin    (yin),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
`ifdef FSMD_DIVZERO_ERR_EN
    .err    (err),
`endif
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, divide-by-zero yields all ones.
  function automatic logic [DW-1:0] model(input int unsigned x, input int unsigned y);
    int unsigned y1, z, y2, x1;
    y1 = y / 3;
    z  = x * x;
    y2 = (z == 0) ? (2**DW - 1) : y1 / z;
    x1 = (x * 2) / 3;
`ifdef FSMD_DIVZERO_ERR_EN
    if (x == 0) return '0;
`endif
    return DW'(x1 - y2);
  endfunction

  // Issue one operation; inj>0 pulses a stray start inj cycles after accept.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int inj);
    logic [DW-1:0] exp;
    int cyc;
    exp = model(int'(x), int'(y));
    check("ready_pre", 32'(ready), 32'd1);
    start = 1'b1;
    xin   = x;
    yin   = y;
    @(posedge clk); #1;
    start = 1'b0;
    xin   = W'($urandom);
    yin   = W'($urandom);
    check("busy_acc", 32'(busy), 32'd1);
    check("ready_acc", 32'(ready), 32'd0);
    cyc = 0;
    while (!done && cyc < 200) begin
      start = (cyc == inj);
      if (start) begin
        xin = W'($urandom);
        yin = W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(LAT));
    check("result", 32'(result), 32'(exp));
`ifdef FSMD_DIVZERO_ERR_EN
    check("err", 32'(err), (x == '0) ? 32'd1 : 32'd0);
`endif
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("result_hold", 32'(result), 32'(exp));
    check("ready_post", 32'(ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    xin   = '0;
    yin   = '0;
    #1;
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_result", 32'(result), 32'd0);

    // Directed cases, including wrap and x=0.
    run_op(4'd3, 4'd9, -1);
    check("dir_3_9", 32'(result), 32'h02);
    run_op(4'd1, 4'd15, -1);
    check("dir_1_15", 32'(result), 32'hFB);
    run_op(4'd0, 4'd6, -1);
`ifdef FSMD_DIVZERO_ERR_EN
    check("dir_0_6", 32'(result), 32'h00);
`else
    check("dir_0_6", 32'(result), 32'h01);
`endif

    // Stray start during DIV_Z must be ignored.
    run_op(4'd2, 4'd13, 12);
    // Stray start on the OUT cycle is ignored too.
    run_op(4'd7, 4'd4, LAT - 1);

    // Randomized operands.
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), -1);
    end

    // Abort mid DIV_Y after a nonzero result is on the output.
    run_op(4'd3, 4'd9, -1);
    start = 1'b1;
    xin   = 4'd5;
    yin   = 4'd14;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_hold", 32'(result), 32'd0);
    run_op(4'd15, 4'd15, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
